// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the decode-stage register scoreboard: default sizes,
// the "no bypass" latency code and the source-address unpacking helper.
package reg_scoreboard_pkg;

    localparam int DEF_NREG   = 32;
    localparam int DEF_AW     = 5;
    localparam int DEF_NSRC   = 3;
    localparam int DEF_LAT_W  = 3;
    localparam int DEF_PEND_W = 2;

    localparam logic [DEF_LAT_W-1:0] LAT_NOFWD = {DEF_LAT_W{1'b1}};

    // Widest source bus / address the unpack helper accepts.
    localparam int SRC_BUS_W  = 64;
    localparam int ADDR_MAX_W = 8;

    typedef struct packed {
        logic [DEF_PEND_W-1:0] pend;
        logic [DEF_LAT_W-1:0]  cnt;
        logic                  nofwd;
    } sb_entry_t;

    function automatic logic [ADDR_MAX_W-1:0] src_unpack(
        input logic [SRC_BUS_W-1:0] bus,
        input int                   port,
        input int                   aw
    );
        logic [SRC_BUS_W-1:0] shifted;
        shifted = bus >> (port * aw);
        return ADDR_MAX_W'(shifted) & ADDR_MAX_W'((1 << aw) - 1);
    endfunction

endpackage

// File: rtl/reg_scoreboard_entry.sv
// Per-register scoreboard state: in-flight writer count, bypass countdown of
// the newest writer and its "wait for writeback" flag.
module sb_entry
    import reg_scoreboard_pkg::*;
#(
    parameter int LAT_W  = DEF_LAT_W,
    parameter int PEND_W = DEF_PEND_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clr,
    input  logic              set,
    input  logic              dec,
    input  logic [LAT_W-1:0]  set_lat,
    input  logic              set_nofwd,
    output logic [PEND_W-1:0] pend,
    output logic [LAT_W-1:0]  cnt,
    output logic              nofwd
);

    logic              dec_eff;
    logic [PEND_W-1:0] pend_nx;

    // A writeback with nothing pending is a stray and must not underflow.
    always_comb begin
        dec_eff = dec & (pend != '0);
        pend_nx = pend;
        if (set & ~dec_eff) begin
            pend_nx = pend + 1'b1;
        end else if (~set & dec_eff) begin
            pend_nx = pend - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend  <= '0;
            cnt   <= '0;
            nofwd <= 1'b0;
        end else if (clr) begin
            pend  <= '0;
            cnt   <= '0;
            nofwd <= 1'b0;
        end else begin
            pend <= pend_nx;
            if (set) begin
                cnt   <= set_lat;
                nofwd <= set_nofwd;
            end else if (pend_nx == '0) begin
                cnt   <= '0;
                nofwd <= 1'b0;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage register scoreboard: per-register pending tracking, source
// hazard / bypass selection and the issue handshake.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NREG   = DEF_NREG,
    parameter int AW     = DEF_AW,
    parameter int NSRC   = DEF_NSRC,
    parameter int LAT_W  = DEF_LAT_W,
    parameter int PEND_W = DEF_PEND_W,
    parameter bit FWD_EN = 1'b1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic               issue_valid,
    output logic               issue_ready,
    input  logic               issue_we,
    input  logic [AW-1:0]      issue_dest,
    input  logic [LAT_W-1:0]   issue_lat,
    input  logic [NSRC-1:0]    src_valid,
    input  logic [NSRC*AW-1:0] src_addr,
    output logic [NSRC-1:0]    src_fwd,
    input  logic               wb_valid,
    input  logic [AW-1:0]      wb_addr,
    output logic [NREG-1:0]    busy_vec
);

    localparam logic [LAT_W-1:0] NOFWD_CODE = {LAT_W{1'b1}};

    logic [NREG-1:0][PEND_W-1:0] pend;
    logic [NREG-1:0][LAT_W-1:0]  cnt;
    logic [NREG-1:0]             nofwd;

    logic             issue_write;
    logic             lat_is_nofwd;
    logic [LAT_W-1:0] set_lat;
    logic             set_nofwd;

    logic [NSRC-1:0]   src_haz;
    logic [AW-1:0]     src_a;
    logic [PEND_W-1:0] sel_pend;
    logic [LAT_W-1:0]  sel_cnt;
    logic              sel_nofwd;
    logic              dest_sat;

    assign pend[0]  = '0;
    assign cnt[0]   = '0;
    assign nofwd[0] = 1'b0;

    assign issue_write  = issue_valid & issue_ready & issue_we & (issue_dest != '0);
    assign lat_is_nofwd = (issue_lat == NOFWD_CODE);
    assign set_lat      = lat_is_nofwd ? '0 : issue_lat;
    assign set_nofwd    = lat_is_nofwd | (FWD_EN == 1'b0);

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        sb_entry #(
            .LAT_W  (LAT_W),
            .PEND_W (PEND_W)
        ) u_entry (
            .clk       (clk),
            .resetn    (resetn),
            .clr       (flush),
            .set       (issue_write & (issue_dest == AW'(r))),
            .dec       (wb_valid & (wb_addr == AW'(r))),
            .set_lat   (set_lat),
            .set_nofwd (set_nofwd),
            .pend      (pend[r]),
            .cnt       (cnt[r]),
            .nofwd     (nofwd[r])
        );
    end

    // Only the newest writer is on the bypass, so a second pending writer
    // always stalls; register 0 never matches and so never hazards.
    always_comb begin
        src_haz   = '0;
        src_fwd   = '0;
        src_a     = '0;
        sel_pend  = '0;
        sel_cnt   = '0;
        sel_nofwd = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            src_a     = AW'(src_unpack(SRC_BUS_W'(src_addr), i, AW));
            sel_pend  = '0;
            sel_cnt   = '0;
            sel_nofwd = 1'b0;
            for (int r = 1; r < NREG; r++) begin
                if (src_a == AW'(r)) begin
                    sel_pend  = pend[r];
                    sel_cnt   = cnt[r];
                    sel_nofwd = nofwd[r];
                end
            end
            if (src_valid[i] && (sel_pend != '0)) begin
                if (sel_nofwd || (sel_cnt != '0) || (sel_pend > PEND_W'(1))) begin
                    src_haz[i] = 1'b1;
                end else begin
                    src_fwd[i] = 1'b1;
                end
            end
        end
    end

    // A full pending counter on the destination would wrap on one more writer.
    always_comb begin
        dest_sat = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            if ((issue_dest == AW'(r)) && (pend[r] == '1)) begin
                dest_sat = 1'b1;
            end
        end
    end

    assign issue_ready = ~(|src_haz) & ~(issue_we & dest_sat);

    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_vec[r] = (pend[r] != '0);
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed vector table, hand sequences for FWD_EN=0
// and async reset, then random traffic against a writer-timeline model.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        issue_valid;
    logic        issue_we;
    logic [4:0]  issue_dest;
    logic [2:0]  issue_lat;
    logic [2:0]  src_valid;
    logic [14:0] src_addr;
    logic        wb_valid;
    logic [4:0]  wb_addr;

    logic        ready_a, ready_b;
    logic [2:0]  fwd_a, fwd_b;
    logic [31:0] busy_a, busy_b;

    int checks   = 0;
    int failures = 0;

    // Model: writer count, cycle at which the newest writer reaches bypass,
    // and whether it ever does. Index 0 follows FWD_EN=1, index 1 FWD_EN=0.
    int cyc = 0;
    int m_pend  [2][32];
    int m_ready [2][32];
    bit m_nofwd [2][32];

    typedef struct {
        logic        fl;
        logic        iv;
        logic        we;
        logic [4:0]  dest;
        logic [2:0]  lat;
        logic [2:0]  sv;
        logic [4:0]  s0, s1, s2;
        logic        wv;
        logic [4:0]  wa;
        logic        e_rdy;
        logic [2:0]  e_fwd;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vq[$];

    reg_scoreboard #(.FWD_EN(1'b1)) dut_a (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_ready (ready_a),
        .issue_we    (issue_we),
        .issue_dest  (issue_dest),
        .issue_lat   (issue_lat),
        .src_valid   (src_valid),
        .src_addr    (src_addr),
        .src_fwd     (fwd_a),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .busy_vec    (busy_a)
    );

    reg_scoreboard #(.FWD_EN(1'b0)) dut_b (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_ready (ready_b),
        .issue_we    (issue_we),
        .issue_dest  (issue_dest),
        .issue_lat   (issue_lat),
        .src_valid   (src_valid),
        .src_addr    (src_addr),
        .src_fwd     (fwd_b),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .busy_vec    (busy_b)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic fl, input logic iv, input logic we,
                                input logic [4:0] dest, input logic [2:0] lat,
                                input logic [2:0] sv, input logic [4:0] s0,
                                input logic [4:0] s1, input logic [4:0] s2,
                                input logic wv, input logic [4:0] wa,
                                input logic e_rdy, input logic [2:0] e_fwd,
                                input logic [31:0] e_busy);
        vec_t v;
        v.fl = fl; v.iv = iv; v.we = we; v.dest = dest; v.lat = lat;
        v.sv = sv; v.s0 = s0; v.s1 = s1; v.s2 = s2; v.wv = wv; v.wa = wa;
        v.e_rdy = e_rdy; v.e_fwd = e_fwd; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic fl, input logic iv, input logic we,
                                 input logic [4:0] dest, input logic [2:0] lat,
                                 input logic [2:0] sv, input logic [4:0] s0,
                                 input logic [4:0] s1, input logic [4:0] s2,
                                 input logic wv, input logic [4:0] wa);
        flush       = fl;
        issue_valid = iv;
        issue_we    = we;
        issue_dest  = dest;
        issue_lat   = lat;
        src_valid   = sv;
        src_addr    = {s2, s1, s0};
        wb_valid    = wv;
        wb_addr     = wa;
    endtask

    function automatic void model_clear(input int k);
        for (int r = 0; r < 32; r++) begin
            m_pend[k][r]  = 0;
            m_ready[k][r] = 0;
            m_nofwd[k][r] = 1'b0;
        end
    endfunction

    function automatic void model_expect(input int k, output logic rdy,
                                         output logic [2:0] fwd, output logic [31:0] busy);
        logic haz;
        int   a;
        haz  = 1'b0;
        fwd  = '0;
        busy = '0;
        for (int r = 1; r < 32; r++) begin
            if (m_pend[k][r] != 0) busy[r] = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            a = int'(src_addr[i*5 +: 5]);
            if (src_valid[i] && a != 0 && m_pend[k][a] != 0) begin
                if (m_pend[k][a] == 1 && !m_nofwd[k][a] && cyc >= m_ready[k][a]) fwd[i] = 1'b1;
                else haz = 1'b1;
            end
        end
        rdy = !haz && !(issue_we && issue_dest != 5'd0 && m_pend[k][issue_dest] == 3);
    endfunction

    task automatic model_update();
        logic        rdy;
        logic [2:0]  f;
        logic [31:0] b;
        bit          s, d;
        for (int k = 0; k < 2; k++) begin
            model_expect(k, rdy, f, b);
            if (flush) begin
                model_clear(k);
            end else begin
                for (int r = 1; r < 32; r++) begin
                    s = issue_valid && rdy && issue_we && (issue_dest == 5'(r));
                    d = wb_valid && (wb_addr == 5'(r)) && m_pend[k][r] > 0;
                    if (s && !d) m_pend[k][r]++;
                    else if (d && !s) m_pend[k][r]--;
                    if (s) begin
                        m_ready[k][r] = cyc + 1 + ((issue_lat == 3'd7) ? 0 : int'(issue_lat));
                        m_nofwd[k][r] = (issue_lat == 3'd7) || (k == 1);
                    end else if (m_pend[k][r] == 0) begin
                        m_nofwd[k][r] = 1'b0;
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic checkModel();
        logic        rdy;
        logic [2:0]  f;
        logic [31:0] b;
        model_expect(0, rdy, f, b);
        checkOutput("model.a.ready", 32'(ready_a), 32'(rdy));
        checkOutput("model.a.fwd",   32'(fwd_a),   32'(f));
        checkOutput("model.a.busy",  busy_a,       b);
        model_expect(1, rdy, f, b);
        checkOutput("model.b.ready", 32'(ready_b), 32'(rdy));
        checkOutput("model.b.fwd",   32'(fwd_b),   32'(f));
        checkOutput("model.b.busy",  busy_b,       b);
    endtask

    task automatic settle();
        @(negedge clk);
        checkModel();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        vec_t v;
        resetn = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_clear(0);
        model_clear(1);

        // Columns: flush iv we dest lat | sv s0 s1 s2 | wv wa | ready fwd busy
        vq.push_back(mk(0,0,0, 0,0, 3'b000, 0,0,0, 0,0, 1,3'b000,32'h0));
        vq.push_back(mk(0,1,1, 5,1, 3'b000, 0,0,0, 0,0, 1,3'b000,32'h0));
        vq.push_back(mk(0,1,0, 0,0, 3'b001, 5,0,0, 0,0, 0,3'b000,32'h20));
        vq.push_back(mk(0,1,0, 0,0, 3'b001, 5,0,0, 0,0, 1,3'b001,32'h20));
        vq.push_back(mk(0,0,0, 0,0, 3'b000, 0,0,0, 1,5, 1,3'b000,32'h20));
        vq.push_back(mk(0,0,0, 0,0, 3'b000, 0,0,0, 0,0, 1,3'b000,32'h0));
        vq.push_back(mk(0,1,1, 7,7, 3'b000, 0,0,0, 0,0, 1,3'b000,32'h0));
        vq.push_back(mk(0,1,0, 0,0, 3'b001, 7,0,0, 0,0, 0,3'b000,32'h80));
        vq.push_back(mk(0,1,0, 0,0, 3'b001, 7,0,0, 1,7, 0,3'b000,32'h80));
        vq.push_back(mk(0,1,0, 0,0, 3'b001, 7,0,0, 0,0, 1,3'b000,32'h0));
        vq.push_back(mk(0,1,1, 3,0, 3'b000, 0,0,0, 0,0, 1,3'b000,32'h0));
        vq.push_back(mk(0,1,1, 3,0, 3'b000, 0,0,0, 0,0, 1,3'b000,32'h8));
        vq.push_back(mk(0,1,0, 0,0, 3'b010, 0,3,0, 1,3, 0,3'b000,32'h8));
        vq.push_back(mk(0,1,0, 0,0, 3'b010, 0,3,0, 0,0, 1,3'b010,32'h8));
        vq.push_back(mk(0,1,0, 0,0, 3'b010, 0,3,0, 1,3, 1,3'b010,32'h8));
        vq.push_back(mk(0,1,0, 0,0, 3'b010, 0,3,0, 0,0, 1,3'b000,32'h0));
        vq.push_back(mk(0,1,1, 4,0, 3'b000, 0,0,0, 0,0, 1,3'b000,32'h0));
        vq.push_back(mk(0,1,1, 4,2, 3'b000, 0,0,0, 1,4, 1,3'b000,32'h10));
        vq.push_back(mk(0,1,0, 0,0, 3'b100, 0,0,4, 0,0, 0,3'b000,32'h10));
        vq.push_back(mk(0,1,0, 0,0, 3'b100, 0,0,4, 0,0, 0,3'b000,32'h10));
        vq.push_back(mk(0,1,0, 0,0, 3'b100, 0,0,4, 0,0, 1,3'b100,32'h10));
        vq.push_back(mk(0,0,0, 0,0, 3'b000, 0,0,0, 1,4, 1,3'b000,32'h10));
        vq.push_back(mk(0,1,1, 9,0, 3'b000, 0,0,0, 0,0, 1,3'b000,32'h0));
        vq.push_back(mk(0,1,1, 9,0, 3'b000, 0,0,0, 0,0, 1,3'b000,32'h200));
        vq.push_back(mk(0,1,1, 9,0, 3'b000, 0,0,0, 0,0, 1,3'b000,32'h200));
        vq.push_back(mk(0,1,1, 9,0, 3'b000, 0,0,0, 0,0, 0,3'b000,32'h200));
        vq.push_back(mk(1,1,1,10,0, 3'b000, 0,0,0, 1,9, 1,3'b000,32'h200));
        vq.push_back(mk(0,0,0, 0,0, 3'b000, 0,0,0, 1,9, 1,3'b000,32'h0));
        vq.push_back(mk(0,1,0, 0,0, 3'b001, 9,0,0, 0,0, 1,3'b000,32'h0));
        vq.push_back(mk(0,1,1, 0,0, 3'b111, 0,0,0, 0,0, 1,3'b000,32'h0));
        vq.push_back(mk(0,0,0, 0,0, 3'b111, 0,0,0, 0,0, 1,3'b000,32'h0));
        vq.push_back(mk(0,0,0, 0,0, 3'b000, 0,0,0, 1,0, 1,3'b000,32'h0));

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.busy",  busy_a,        32'h0);
        checkOutput("reset.ready", 32'(ready_a),  32'h1);
        checkOutput("reset.fwd",   32'(fwd_a),    32'h0);
        @(posedge clk);
        #2 resetn = 1'b1;

        for (int n = 0; n < vq.size(); n++) begin
            v = vq[n];
            applyStimulus(v.fl, v.iv, v.we, v.dest, v.lat, v.sv, v.s0, v.s1, v.s2, v.wv, v.wa);
            settle();
            checkOutput($sformatf("vec%0d.ready", n), 32'(ready_a), 32'(v.e_rdy));
            checkOutput($sformatf("vec%0d.fwd", n),   32'(fwd_a),   32'(v.e_fwd));
            checkOutput($sformatf("vec%0d.busy", n),  busy_a,       v.e_busy);
            tick();
        end

        // FWD_EN=0: a latency-0 writer still holds its consumer until writeback.
        applyStimulus(0, 1, 1, 12, 0, 3'b000, 0, 0, 0, 0, 0);
        settle();
        checkOutput("nofwd.issue.ready_b", 32'(ready_b), 32'h1);
        tick();
        applyStimulus(0, 1, 0, 0, 0, 3'b001, 12, 0, 0, 0, 0);
        settle();
        checkOutput("nofwd.use.ready_a", 32'(ready_a), 32'h1);
        checkOutput("nofwd.use.fwd_a",   32'(fwd_a),   32'h1);
        checkOutput("nofwd.use.ready_b", 32'(ready_b), 32'h0);
        checkOutput("nofwd.use.fwd_b",   32'(fwd_b),   32'h0);
        checkOutput("nofwd.use.busy_b",  busy_b,       32'h1000);
        tick();
        applyStimulus(0, 1, 0, 0, 0, 3'b001, 12, 0, 0, 1, 12);
        settle();
        checkOutput("nofwd.wb.ready_b", 32'(ready_b), 32'h0);
        tick();
        applyStimulus(0, 1, 0, 0, 0, 3'b001, 12, 0, 0, 0, 0);
        settle();
        checkOutput("nofwd.after.ready_b", 32'(ready_b), 32'h1);
        checkOutput("nofwd.after.busy_b",  busy_b,       32'h0);
        tick();

        // Asynchronous reset with a writer in flight.
        applyStimulus(0, 1, 1, 20, 7, 3'b000, 0, 0, 0, 0, 0);
        settle();
        tick();
        applyStimulus(0, 1, 0, 0, 0, 3'b001, 20, 0, 0, 0, 0);
        settle();
        checkOutput("areset.before.busy",  busy_a,       32'h100000);
        checkOutput("areset.before.ready", 32'(ready_a), 32'h0);
        #2 resetn = 1'b0;
        #1;
        checkOutput("areset.busy_a",  busy_a,       32'h0);
        checkOutput("areset.busy_b",  busy_b,       32'h0);
        checkOutput("areset.ready_a", 32'(ready_a), 32'h1);
        model_clear(0);
        model_clear(1);
        @(posedge clk);
        #2 resetn = 1'b1;
        applyStimulus(0, 1, 0, 0, 0, 3'b001, 20, 0, 0, 0, 0);
        settle();
        checkOutput("areset.after.ready", 32'(ready_a), 32'h1);
        tick();

        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 31) == 0,
                          $urandom_range(0, 3) != 0,
                          1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)),
                          $urandom_range(0, 2) == 0,
                          5'($urandom_range(0, 7)));
            settle();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
